// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile-flip issuer: default widths, picture-ID type,
// flip FSM states and the wrap-around increment used for the player track.
package tile_pkg;

  localparam int DEF_TILE_W = 4;
  localparam int DEF_IDX_W  = 5;

  typedef logic [DEF_TILE_W-1:0] tile_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_CTR  = 3'd1,
    S_EDGE = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } flip_state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    if (v + 1 >= n) return 0;
    else return v + 1;
  endfunction

endpackage

// File: rtl/tile_board_ram.sv
// Picture board: DEPTH entries of TILE_W bits, one write port, one async read port.
// Out-of-range writes are dropped and out-of-range reads return 0.
module tile_board_ram #(
  parameter int DEPTH  = 24,
  parameter int TILE_W = 4,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [TILE_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [TILE_W-1:0] rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TILE_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = we_i && ({1'b0, waddr_i} < (IDX_W+1)'(DEPTH));
  assign rd_ok = {1'b0, raddr_i} < (IDX_W+1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = rd_ok ? mem_q[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/tile_flip_issuer.sv
// Game-side initiator for the tile-match comparator: presents center then edge tile,
// samples the comparator result and advances the player. Optional: TILE_CROSSCHECK_EN.
module tile_flip_issuer
  import tile_pkg::*;
#(
  parameter int N_EDGE   = 24,
  parameter int N_CENTER = 12,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [TILE_W-1:0] load_tile,
  input  logic              flip_req,
  input  logic [IDX_W-1:0]  flip_idx,
  output logic              flip_ready,
  output logic [TILE_W-1:0] position_data,
  output logic              A,
  input  logic              result_in,
  output logic              flip_done,
  output logic              flip_match,
  output logic              flip_bad,
  output logic [IDX_W-1:0]  player_pos
`ifdef TILE_CROSSCHECK_EN
  ,
  output logic              xchk_err
`endif
);

  flip_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic [TILE_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              a_q, a_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic              bad_q, bad_d;

  logic              idle;
  logic              in_range;
  logic              accept;
  logic              reject;
  logic [IDX_W-1:0]  pos_next;
  logic [IDX_W-1:0]  ctr_raddr;
  logic [TILE_W-1:0] ctr_rd;
  logic [TILE_W-1:0] edge_rd;
  logic              edge_we;
  logic              ctr_we;

  assign idle     = (state_q == IDLE);
  assign in_range = {1'b0, flip_idx} < (IDX_W+1)'(N_CENTER);
  assign accept   = idle && flip_req && in_range;
  assign reject   = idle && flip_req && !in_range;
  assign pos_next = IDX_W'(wrap_inc(32'(pos_q), N_EDGE));

  // An accepted flip reads the board before this cycle's load lands
  assign ctr_raddr = accept ? flip_idx : idx_q;

  // Loads only while idle so a flip in flight never sees a half-updated board
  assign edge_we = load_en && !load_sel && idle;
  assign ctr_we  = load_en && load_sel && idle;

  tile_board_ram #(
    .DEPTH (N_EDGE),
    .TILE_W(TILE_W),
    .IDX_W (IDX_W)
  ) u_edge_board (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (edge_we),
    .waddr_i(load_idx),
    .wdata_i(load_tile),
    .raddr_i(pos_next),
    .rdata_o(edge_rd)
  );

  tile_board_ram #(
    .DEPTH (N_CENTER),
    .TILE_W(TILE_W),
    .IDX_W (IDX_W)
  ) u_center_board (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ctr_we),
    .waddr_i(load_idx),
    .wdata_i(load_tile),
    .raddr_i(ctr_raddr),
    .rdata_o(ctr_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flip_req) state_d = in_range ? S_CTR : S_DONE;
      end
      S_CTR:   state_d = S_EDGE;
      S_EDGE:  state_d = S_CMP;
      S_CMP:   state_d = S_DONE;
      S_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    ready_d = (state_d == IDLE);
    a_d     = (state_d == S_EDGE) || (state_d == S_CMP);
    done_d  = (state_d == S_DONE);
    idx_d   = accept ? flip_idx : idx_q;
    data_d  = data_q;
    match_d = match_q;
    bad_d   = bad_q;
    pos_d   = pos_q;

    unique case (state_d)
      S_EDGE:  data_d = edge_rd;
      S_CMP:   data_d = data_q;
      default: data_d = ctr_rd;
    endcase

    if (accept) begin
      bad_d = 1'b0;
    end else if (reject) begin
      bad_d   = 1'b1;
      match_d = 1'b0;
    end

    if (state_q == S_CMP) match_d = result_in;
    if (state_q == S_DONE && match_q) pos_d = pos_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      a_q     <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      bad_q   <= 1'b0;
      pos_q   <= '0;
      idx_q   <= '0;
    end else begin
      ready_q <= ready_d;
      a_q     <= a_d;
      data_q  <= data_d;
      done_q  <= done_d;
      match_q <= match_d;
      bad_q   <= bad_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
    end
  end

  assign flip_ready    = ready_q;
  assign A             = a_q;
  assign position_data = data_q;
  assign flip_done     = done_q;
  assign flip_match    = match_q;
  assign flip_bad      = bad_q;
  assign player_pos    = pos_q;

`ifdef TILE_CROSSCHECK_EN
  logic xchk_q;

  // Local equality check against the comparator's verdict, sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xchk_q <= 1'b0;
    else if (state_q == S_CMP && ((ctr_rd == edge_rd) != result_in)) xchk_q <= 1'b1;
  end

  assign xchk_err = xchk_q;
`endif

endmodule

// File: tb/tb_tile_flip_issuer.sv
// Directed bench for tile_flip_issuer with a behavioural tile-match comparator.
module tb_tile_flip_issuer;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       load_sel;
  logic [4:0] load_idx;
  logic [3:0] load_tile;
  logic       flip_req;
  logic [4:0] flip_idx;
  logic       flip_ready;
  logic [3:0] position_data;
  logic       A;
  logic       result_in;
  logic       flip_done;
  logic       flip_match;
  logic       flip_bad;
  logic [4:0] player_pos;
`ifdef TILE_CROSSCHECK_EN
  logic       xchk_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  tile_flip_issuer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en      (load_en),
    .load_sel     (load_sel),
    .load_idx     (load_idx),
    .load_tile    (load_tile),
    .flip_req     (flip_req),
    .flip_idx     (flip_idx),
    .flip_ready   (flip_ready),
    .position_data(position_data),
    .A            (A),
    .result_in    (result_in),
    .flip_done    (flip_done),
    .flip_match   (flip_match),
    .flip_bad     (flip_bad),
    .player_pos   (player_pos)
`ifdef TILE_CROSSCHECK_EN
    ,
    .xchk_err     (xchk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: latches the bus every edge into the center or edge slot
  logic [3:0] cmp_ctr, cmp_edge;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_ctr  <= 4'h0;
      cmp_edge <= 4'h0;
    end else if (A) begin
      cmp_edge <= position_data;
    end else begin
      cmp_ctr <= position_data;
    end
  end
  assign result_in = (cmp_ctr == cmp_edge);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load(input logic sel, input logic [4:0] idx, input logic [3:0] tile);
    load_en   = 1'b1;
    load_sel  = sel;
    load_idx  = idx;
    load_tile = tile;
    tick();
    load_en = 1'b0;
  endtask

  task automatic flip(input string tag, input logic [4:0] idx, input logic [3:0] exp_ctr,
                      input logic [3:0] exp_edge, input logic exp_match, input logic [4:0] exp_pos);
    chk({tag, ".ready_in"}, 32'(flip_ready), 32'd1);
    flip_req = 1'b1;
    flip_idx = idx;
    tick();
    flip_req = 1'b0;
    chk({tag, ".c1_A"}, 32'(A), 32'd0);
    chk({tag, ".c1_data"}, 32'(position_data), 32'(exp_ctr));
    chk({tag, ".c1_ready"}, 32'(flip_ready), 32'd0);
    tick();
    chk({tag, ".c2_A"}, 32'(A), 32'd1);
    chk({tag, ".c2_data"}, 32'(position_data), 32'(exp_edge));
    tick();
    chk({tag, ".c3_A"}, 32'(A), 32'd1);
    chk({tag, ".c3_data"}, 32'(position_data), 32'(exp_edge));
    chk({tag, ".c3_done"}, 32'(flip_done), 32'd0);
    tick();
    chk({tag, ".c4_done"}, 32'(flip_done), 32'd1);
    chk({tag, ".c4_match"}, 32'(flip_match), 32'(exp_match));
    chk({tag, ".c4_bad"}, 32'(flip_bad), 32'd0);
    tick();
    chk({tag, ".c5_done"}, 32'(flip_done), 32'd0);
    chk({tag, ".c5_ready"}, 32'(flip_ready), 32'd1);
    chk({tag, ".c5_A"}, 32'(A), 32'd0);
    chk({tag, ".c5_pos"}, 32'(player_pos), 32'(exp_pos));
  endtask

  initial begin
    rst_n     = 1'b0;
    load_en   = 1'b0;
    load_sel  = 1'b0;
    load_idx  = 5'd0;
    load_tile = 4'h0;
    flip_req  = 1'b0;
    flip_idx  = 5'd0;
    #12;
    chk("rst.ready", 32'(flip_ready), 32'd1);
    chk("rst.A", 32'(A), 32'd0);
    chk("rst.data", 32'(position_data), 32'd0);
    chk("rst.done", 32'(flip_done), 32'd0);
    chk("rst.match", 32'(flip_match), 32'd0);
    chk("rst.bad", 32'(flip_bad), 32'd0);
    chk("rst.pos", 32'(player_pos), 32'd0);
    rst_n = 1'b1;
    tick();

    // Matching flip: center[3]=7 against edge[1]=7
    load(1'b0, 5'd1, 4'h7);
    load(1'b1, 5'd3, 4'h7);
    flip("match", 5'd3, 4'h7, 4'h7, 1'b1, 5'd1);

    // Miss leaves the player in place; a repeat flip shows the same bus sequence
    do_reset();
    load(1'b0, 5'd1, 4'h7);
    load(1'b1, 5'd3, 4'h2);
    flip("miss1", 5'd3, 4'h2, 4'h7, 1'b0, 5'd0);
    flip("miss2", 5'd3, 4'h2, 4'h7, 1'b0, 5'd0);

    // Walk the player to 23 and wrap to 0
    for (int i = 0; i < 24; i++) load(1'b0, 5'(i), 4'h5);
    load(1'b1, 5'd0, 4'h5);
    for (int i = 0; i < 23; i++) flip("walk", 5'd0, 4'h5, 4'h5, 1'b1, 5'(i + 1));
    chk("wrap.pre_pos", 32'(player_pos), 32'd23);
    flip("wrap", 5'd0, 4'h5, 4'h5, 1'b1, 5'd0);

    // Out-of-range index completes after one cycle with no edge presentation
    flip_req = 1'b1;
    flip_idx = 5'd12;
    tick();
    flip_req = 1'b0;
    chk("bad.done", 32'(flip_done), 32'd1);
    chk("bad.bad", 32'(flip_bad), 32'd1);
    chk("bad.match", 32'(flip_match), 32'd0);
    chk("bad.A", 32'(A), 32'd0);
    chk("bad.ready", 32'(flip_ready), 32'd0);
    tick();
    chk("bad.done_after", 32'(flip_done), 32'd0);
    chk("bad.ready_after", 32'(flip_ready), 32'd1);
    chk("bad.A_after", 32'(A), 32'd0);
    chk("bad.held", 32'(flip_bad), 32'd1);
    chk("bad.pos", 32'(player_pos), 32'd0);

    // Flip and load during S_EDGE are ignored
    flip_req = 1'b1;
    flip_idx = 5'd0;
    tick();
    flip_req = 1'b0;
    chk("busy.bad_cleared", 32'(flip_bad), 32'd0);
    tick();
    chk("busy.edge_A", 32'(A), 32'd1);
    flip_req  = 1'b1;
    flip_idx  = 5'd0;
    load_en   = 1'b1;
    load_sel  = 1'b1;
    load_idx  = 5'd0;
    load_tile = 4'h9;
    tick();
    flip_req = 1'b0;
    load_en  = 1'b0;
    chk("busy.cmp_ready", 32'(flip_ready), 32'd0);
    tick();
    chk("busy.done", 32'(flip_done), 32'd1);
    chk("busy.match", 32'(flip_match), 32'd1);
    tick();
    chk("busy.done_low", 32'(flip_done), 32'd0);
    chk("busy.pos", 32'(player_pos), 32'd1);
    chk("busy.idle_data", 32'(position_data), 32'h5);
    tick();
    chk("busy.no_second_done", 32'(flip_done), 32'd0);
    chk("busy.ready", 32'(flip_ready), 32'd1);
    flip("busy.after", 5'd0, 4'h5, 4'h5, 1'b1, 5'd2);

    // Reset during S_CMP: outputs return to reset values without a clock edge
    flip_req = 1'b1;
    flip_idx = 5'd0;
    tick();
    flip_req = 1'b0;
    tick();
    tick();
    chk("rstmid.in_cmp", 32'(A), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.ready", 32'(flip_ready), 32'd1);
    chk("rstmid.A", 32'(A), 32'd0);
    chk("rstmid.data", 32'(position_data), 32'd0);
    chk("rstmid.done", 32'(flip_done), 32'd0);
    chk("rstmid.match", 32'(flip_match), 32'd0);
    chk("rstmid.bad", 32'(flip_bad), 32'd0);
    chk("rstmid.pos", 32'(player_pos), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid.no_done1", 32'(flip_done), 32'd0);
    tick();
    chk("rstmid.no_done2", 32'(flip_done), 32'd0);
    load(1'b0, 5'd1, 4'h3);
    load(1'b1, 5'd2, 4'h3);
    flip("rstmid.next", 5'd2, 4'h3, 4'h3, 1'b1, 5'd1);

    // Load and flip in the same idle cycle: the flip sees the old tile
    load(1'b1, 5'd4, 4'h6);
    load_en   = 1'b1;
    load_sel  = 1'b1;
    load_idx  = 5'd4;
    load_tile = 4'h8;
    flip_req  = 1'b1;
    flip_idx  = 5'd4;
    tick();
    load_en  = 1'b0;
    flip_req = 1'b0;
    chk("same.ctr_data", 32'(position_data), 32'h6);
    tick();
    chk("same.edge_data", 32'(position_data), 32'h0);
    tick();
    tick();
    chk("same.done", 32'(flip_done), 32'd1);
    chk("same.match", 32'(flip_match), 32'd0);
    tick();
    chk("same.pos", 32'(player_pos), 32'd1);
    flip("same.next", 5'd4, 4'h8, 4'h0, 1'b0, 5'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
